// File: rtl/ili_spi_slave.sv
// SPI mode-0 slave modelling the display end of a 4-wire ILI9341 link.
// Oversamples the pins on clk, deserialises dc-tagged bytes and shifts a preloaded response on miso.
module ili_spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              dc,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_dc,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [7:0]        byte_cnt,
    output logic              frame_end,
    output logic              overrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Pin bundle layout: {dc, mosi, sclk, cs}
    localparam int PIN_CS   = 0;
    localparam int PIN_SCLK = 1;
    localparam int PIN_MOSI = 2;
    localparam int PIN_DC   = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                           state_r;
    state_t                           state_nxt_s;
    logic [SYNC_STAGES-1:0][3:0]      sync_r;
    logic [3:0]                       pins_s;
    logic [3:0]                       sync_out_s;
    logic                             cs_hist_r;
    logic                             sclk_hist_r;
    logic                             cs_rise_s;
    logic                             cs_fall_s;
    logic                             sclk_rise_s;
    logic                             sclk_fall_s;
    logic                             frame_start_s;
    logic                             frame_stop_s;
    logic                             rx_shift_en_s;
    logic                             tx_shift_en_s;
    logic [DATA_W-1:0]                tx_next_s;
    logic [DATA_W-1:0]                shift_rx_r;
    logic [DATA_W-1:0]                shift_tx_r;
    logic [DATA_W-1:0]                tx_buf_r;
    logic [CNT_W-1:0]                 bit_cnt_r;
    logic [CNT_W-1:0]                 tx_cnt_r;
    logic                             byte_done_r;
    logic                             dc_cap_r;

    assign pins_s      = {dc, mosi, sclk, cs};
    assign sync_out_s  = sync_r[SYNC_STAGES-1];
    assign cs_rise_s   =  sync_out_s[PIN_CS]   & ~cs_hist_r;
    assign cs_fall_s   = ~sync_out_s[PIN_CS]   &  cs_hist_r;
    assign sclk_rise_s =  sync_out_s[PIN_SCLK] & ~sclk_hist_r;
    assign sclk_fall_s = ~sync_out_s[PIN_SCLK] &  sclk_hist_r;

    // Pin synchronisers plus one history stage for cs/sclk edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r      <= {(SYNC_STAGES*4){1'b0}};
            cs_hist_r   <= 1'b0;
            sclk_hist_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], pins_s};
            cs_hist_r   <= sync_out_s[PIN_CS];
            sclk_hist_r <= sync_out_s[PIN_SCLK];
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle frame strobes; cs_rise masks any sclk edge in the same cycle
    always_comb begin
        state_nxt_s   = state_r;
        frame_start_s = 1'b0;
        frame_stop_s  = 1'b0;
        rx_shift_en_s = 1'b0;
        tx_shift_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s   = ST_ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_nxt_s  = ST_IDLE;
                    frame_stop_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_ACTIVE;
                    rx_shift_en_s = sclk_rise_s;
                    tx_shift_en_s = sclk_fall_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A load in the same cycle as a reload must win, so reloads read through this mux
    assign tx_next_s = tx_load ? tx_data : tx_buf_r;

    // Response buffer, loadable in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf_r <= {DATA_W{1'b0}};
        end else if (tx_load) begin
            tx_buf_r <= tx_data;
        end
    end

    // Receive shifter, bit counter and byte counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_rx_r  <= {DATA_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            byte_cnt    <= 8'd0;
            byte_done_r <= 1'b0;
            dc_cap_r    <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (frame_start_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
                byte_cnt  <= 8'd0;
            end else if (frame_stop_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (rx_shift_en_s) begin
                shift_rx_r <= {shift_rx_r[DATA_W-2:0], sync_out_s[PIN_MOSI]};
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r   <= {CNT_W{1'b0}};
                    byte_done_r <= 1'b1;
                    dc_cap_r    <= sync_out_s[PIN_DC];
                    if (byte_cnt != 8'hFF) begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Transmit shifter: miso changes on sclk falls so the master samples it on the next rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_tx_r <= {DATA_W{1'b0}};
            tx_cnt_r   <= {CNT_W{1'b0}};
            miso       <= 1'b0;
        end else if (frame_start_s) begin
            shift_tx_r <= tx_next_s;
            tx_cnt_r   <= {CNT_W{1'b0}};
            miso       <= tx_next_s[DATA_W-1];
        end else if (frame_stop_s) begin
            tx_cnt_r <= {CNT_W{1'b0}};
            miso     <= 1'b0;
        end else if (tx_shift_en_s) begin
            if (tx_cnt_r == LAST_BIT) begin
                tx_cnt_r   <= {CNT_W{1'b0}};
                shift_tx_r <= tx_next_s;
                miso       <= tx_next_s[DATA_W-1];
            end else begin
                tx_cnt_r   <= tx_cnt_r + CNT_W'(1);
                shift_tx_r <= {shift_tx_r[DATA_W-2:0], 1'b0};
                miso       <= shift_tx_r[DATA_W-2];
            end
        end
    end

    // Holding register: a byte landing while the slot is full and not being taken is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= {DATA_W{1'b0}};
            rx_dc    <= 1'b0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (byte_done_r) begin
            if (!rx_valid || rx_ready) begin
                rx_data  <= shift_rx_r;
                rx_dc    <= dc_cap_r;
                rx_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Frame-end pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_end <= 1'b0;
        end else begin
            frame_end <= frame_stop_s;
        end
    end

endmodule

// File: tb/tb_ili_spi_slave.sv
// Self-checking bench for ili_spi_slave: byte table, randomized frames against a queue model,
// and directed sequences for overrun, aborted bytes and reset during a frame.
module tb_ili_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, sclk, mosi, dc;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] byte_cnt;
    logic       frame_end, overrun;

    logic       ready_man, ready_rand, rand_mode;
    int         checks = 0;
    int         failures = 0;
    int         fe_cnt = 0;
    logic [8:0] got_q[$];

    assign rx_ready = rand_mode ? ready_rand : ready_man;

    ili_spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .dc(dc),
        .miso(miso), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_load(tx_load),
        .byte_cnt(byte_cnt), .frame_end(frame_end), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Consumer side: record every accepted byte and every frame_end cycle
    always @(posedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({rx_dc, rx_data});
        if (frame_end) fe_cnt++;
    end

    always @(negedge clk) ready_rand <= 1'($urandom_range(0, 1));

    typedef struct {
        logic [7:0] mosi_byte;
        logic       dc_bit;
        logic [7:0] tx_byte;
        logic       last;
        logic [7:0] exp_rx;
        logic       exp_dc;
        logic [7:0] exp_miso;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clks(1);
        tx_load = 1'b0;
    endtask

    task automatic begin_frame();
        cs = 1'b0;
        wait_clks(6);
    endtask

    task automatic end_frame();
        cs = 1'b1;
        wait_clks(10);
    endtask

    // Master side of mode 0: drive before the rise, sample miso on the rise, sclk = clk/10
    task automatic spi_bits(input logic [7:0] b, input logic dv, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            dc   = dv;
            wait_clks(5);
            sclk = 1'b1;
            r[7-i] = miso;
            wait_clks(5);
            sclk = 1'b0;
        end
    endtask

    task automatic check_rx(input string name, input logic exp_dcv, input logic [7:0] exp_d);
        logic [8:0] got;
        check({name, "_avail"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            check({name, "_data"}, 32'(got[7:0]), 32'(exp_d));
            check({name, "_dc"}, 32'(got[8]), 32'(exp_dcv));
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({miso, rx_data, rx_dc, rx_valid, byte_cnt, frame_end, overrun});
    endfunction

    initial begin
        vec_t       tbl[7];
        logic [7:0] r;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        int         fe0, nb;
        logic [7:0] txv, d;
        logic       dv;

        tbl[0] = '{8'h2A, 1'b0, 8'hD3, 1'b1, 8'h2A, 1'b0, 8'hD3};
        tbl[1] = '{8'h00, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 8'h5C};
        tbl[2] = '{8'hFF, 1'b1, 8'h5C, 1'b0, 8'hFF, 1'b1, 8'h5C};
        tbl[3] = '{8'hA5, 1'b1, 8'h5C, 1'b0, 8'hA5, 1'b1, 8'h5C};
        tbl[4] = '{8'h3C, 1'b1, 8'h5C, 1'b1, 8'h3C, 1'b1, 8'h5C};
        tbl[5] = '{8'h81, 1'b0, 8'hD3, 1'b0, 8'h81, 1'b0, 8'hD3};
        tbl[6] = '{8'h7E, 1'b0, 8'hD3, 1'b1, 8'h7E, 1'b0, 8'hD3};

        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0; ready_man = 1'b1; rand_mode = 1'b0;
        wait_clks(4);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b1;
        wait_clks(10);
        check("idle_after_reset", all_outs(), 32'd0);

        // Table: single-byte frame, a four-byte data frame, and a repeated response byte
        nb = 0;
        fe0 = fe_cnt;
        for (int i = 0; i < 7; i++) begin
            if (nb == 0) begin
                load_tx(tbl[i].tx_byte);
                begin_frame();
                fe0 = fe_cnt;
            end
            spi_bits(tbl[i].mosi_byte, tbl[i].dc_bit, 8, r);
            nb++;
            check_rx($sformatf("tbl%0d_rx", i), tbl[i].exp_dc, tbl[i].exp_rx);
            check($sformatf("tbl%0d_miso", i), 32'(r), 32'(tbl[i].exp_miso));
            if (tbl[i].last) begin
                end_frame();
                check($sformatf("tbl%0d_byte_cnt", i), 32'(byte_cnt), 32'(nb));
                check($sformatf("tbl%0d_frame_end", i), 32'(fe_cnt - fe0), 32'd1);
                check($sformatf("tbl%0d_miso_idle", i), 32'(miso), 32'd0);
                check($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'd0);
                nb = 0;
            end
        end

        // Randomized frames with a jittering consumer; model: every byte arrives once, in order
        rand_mode = 1'b1;
        for (int f = 0; f < 5; f++) begin
            txv = 8'($urandom);
            load_tx(txv);
            begin_frame();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                d  = 8'($urandom);
                dv = 1'($urandom_range(0, 1));
                exp_q.push_back({dv, d});
                spi_bits(d, dv, 8, r);
                check($sformatf("rnd%0d_miso%0d", f, k), 32'(r), 32'(txv));
            end
            end_frame();
            check($sformatf("rnd%0d_byte_cnt", f), 32'(byte_cnt), 32'(nb));
            check($sformatf("rnd%0d_count", f), 32'(got_q.size()), 32'(exp_q.size()));
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("rnd%0d_byte", f), 32'(got_q.pop_front()), 32'(e));
            end
            exp_q.delete();
            got_q.delete();
        end
        rand_mode = 1'b0;
        check("rnd_overrun", 32'(overrun), 32'd0);

        // Frame aborted after 5 bits, then a clean byte
        begin_frame();
        spi_bits(8'hFF, 1'b1, 5, r);
        end_frame();
        check("partial_no_output", 32'(got_q.size()), 32'd0);
        check("partial_no_valid", 32'(rx_valid), 32'd0);
        begin_frame();
        spi_bits(8'h5A, 1'b0, 8, r);
        end_frame();
        check_rx("after_partial", 1'b0, 8'h5A);
        check("after_partial_byte_cnt", 32'(byte_cnt), 32'd1);

        // Overrun: second byte dropped while the consumer stalls
        ready_man = 1'b0;
        begin_frame();
        spi_bits(8'h11, 1'b0, 8, r);
        spi_bits(8'h22, 1'b0, 8, r);
        end_frame();
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_byte_cnt", 32'(byte_cnt), 32'd2);
        ready_man = 1'b1;
        wait_clks(2);
        check_rx("ovr_accept", 1'b0, 8'h11);
        check("ovr_valid_clear", 32'(rx_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_nothing_else", 32'(got_q.size()), 32'd0);

        // Reset during bit 4 with a byte held, released while cs is still low
        ready_man = 1'b0;
        load_tx(8'hC3);
        begin_frame();
        spi_bits(8'h99, 1'b1, 8, r);
        spi_bits(8'hF0, 1'b1, 4, r);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        wait_clks(3);
        rst = 1'b1;
        ready_man = 1'b1;
        wait_clks(4);
        spi_bits(8'h77, 1'b1, 8, r);
        wait_clks(6);
        check("post_rst_ignored_valid", 32'(rx_valid), 32'd0);
        check("post_rst_ignored_cnt", 32'(byte_cnt), 32'd0);
        check("post_rst_miso", 32'(miso), 32'd0);
        check("post_rst_no_accept", 32'(got_q.size()), 32'd0);
        end_frame();
        begin_frame();
        spi_bits(8'h5A, 1'b1, 8, r);
        check("post_rst_txbuf_cleared", 32'(r), 32'h00);
        end_frame();
        check_rx("post_rst_frame", 1'b1, 8'h5A);
        check("post_rst_byte_cnt", 32'(byte_cnt), 32'd1);
        check("post_rst_overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ili_spi_slave.md
Name: ili_spi_slave

Overview:
- SPI mode-0 slave (CPOL=0, CPHA=0, MSB first). It models the display end of the 4-wire ILI9341 link driven by the SPI master chain.
- Oversamples the cs/sclk/mosi/dc pins on the system clock and deserialises each byte. Each byte is tagged with the dc level sampled at its last bit and handed to a consumer through a valid/ready holding register.
- Serialises a preloaded response byte on miso during register reads.
- Used as a loopback target and bench model for ili_init_ctrl/spi_ctrl/spi_shift.

Parameters:
- DATA_W, 8, bits per SPI word; also the width of rx_data and tx_data.
- SYNC_STAGES, 2, flip-flop synchroniser depth on cs, sclk, mosi and dc (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select from master, active-low.
- sclk  in  1  SPI clock from master; idles low.
- mosi  in  1  serial data from master.
- dc  in  1  data/command select from master (0 = command, 1 = data).
- miso  out  1  serial data to master.
- rx_data  out  DATA_W  received byte.
- rx_dc  out  1  dc level captured with rx_data.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when high together with rx_valid.
- tx_data  in  DATA_W  response byte.
- tx_load  in  1  one-cycle strobe; latches tx_data as the next byte to shift out.
- byte_cnt  out  8  bytes completed since the last cs falling edge; saturates at 255.
- frame_end  out  1  one-cycle pulse on cs rising edge.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, including miso, rx_data, rx_dc, rx_valid, byte_cnt, frame_end and overrun. Shift register, bit counter, tx buffer and synchronisers are also cleared.
- Synchronisation: each of cs, sclk, mosi, dc passes through SYNC_STAGES flops plus one extra history flop for edge detection.
  - sclk_rise = sync & ~hist; sclk_fall = ~sync & hist. cs_fall and cs_rise are derived the same way.
- Frame states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on cs_fall. On entry: bit_cnt=0, byte_cnt=0, tx shift register <= tx buffer, miso <= tx buffer MSB.
  - ACTIVE -> IDLE on cs_rise. frame_end pulses for 1 cycle. A partial byte (bit_cnt != 0) is discarded silently and bit_cnt is reset.
- sclk edges are ignored in IDLE; miso holds 0 in IDLE.
- Receive:
  - On sclk_rise in ACTIVE: shift_rx <= {shift_rx[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - On the DATA_W-th rise: bit_cnt wraps to 0. The completed byte and dc_sync are written to the holding register and rx_valid=1 on the next cycle. byte_cnt increments, saturating at 255.
  - Latency: with the default parameters, rx_valid rises on the 4th clk rising edge after the final sclk rising edge reaches the pin.
- Holding register handshake:
  - rx_valid & rx_ready in a cycle -> rx_valid=0 next cycle.
  - A new byte completing in the same cycle as acceptance -> the new byte is loaded and rx_valid stays 1. This is not an overrun.
  - A new byte completing while rx_valid=1 and rx_ready=0 -> the old byte is kept, the new byte is dropped, and overrun <= 1.
  - rx_data and rx_dc are stable while rx_valid=1.
- Transmit:
  - tx_load latches tx_data into the tx buffer in any state.
  - On sclk_fall in ACTIVE: the tx shift register shifts left and miso <= the next bit.
  - After the DATA_W-th fall, the tx shift register reloads from the tx buffer. If tx_load was not strobed, the same byte repeats.
  - tx_load on the same cycle as a reload: the new tx_data is used for the reload.
- Simultaneous cs_rise and sclk_rise in one cycle: cs_rise wins and the sclk edge is ignored.
- Reset mid-frame: everything clears immediately. After rst is released, the block waits for a fresh cs_fall; cs already low at release does not start a frame.

Test Plan:
1. Reset, then cs low, dc=0, send 0x2A at sclk=clk/10 -> one rx_valid, rx_data=0x2A, rx_dc=0; byte_cnt=1; frame_end pulse on cs high.
2. One frame with dc=1 throughout, bytes 0x00,0xFF,0xA5,0x3C, rx_ready held 1 -> four accepts in order, each rx_dc=1; byte_cnt=4; overrun=0.
3. rx_ready=0 while bytes 0x11 then 0x22 arrive -> rx_data stays 0x11, overrun=1. Raise rx_ready -> 0x11 accepted, rx_valid=0.
4. tx_load 0xD3 before cs_fall; master clocks 16 bits -> master receives 0xD3 twice on miso. miso=0 once cs is high.
5. cs high after 5 bits, then a full frame carrying 0x5A -> no output from the partial byte; next byte received as 0x5A.
6. Assert rst during bit 4 with rx_valid=1 -> all outputs 0 asynchronously. Release rst with cs still low -> sclk edges ignored until cs toggles high then low.
